// File: rtl/bus_master_port.sv
// Master-side endpoint of the two-master serial bus: request, serialise address/data, collect read data.
// Optional read-wait timeout enabled by defining BUS_MASTER_PORT_TIMEOUT_EN.
module bus_master_port #(
  parameter int ADDR_WIDTH     = 14,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  breq,
  input  logic                  bgrant,
  input  logic                  msplit,
  input  logic                  sready,
  output logic                  mvalid,
  output logic                  mdata,
  output logic                  mmode,
  input  logic                  svalid,
  input  logic                  sdata
);

  localparam int MAXW = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int CW   = $clog2(MAXW) + 1;

  typedef enum logic [3:0] {
    IDLE, REQ, ADDR, WDATA, RWAIT, RDATA, SPLIT, RESUME, DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d, addr_sh;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d, wdata_sh;
  logic                    write_q, write_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    breq_q, breq_d;
  logic                    mvalid_q, mvalid_d;
  logic                    mdata_q, mdata_d;
  logic                    mmode_q, mmode_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                    rsp_err_q, rsp_err_d;
  logic                    timeout;

`ifdef BUS_MASTER_PORT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_q, to_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    write_d = write_q;
    rdata_d = rdata_q;
    timeout = 1'b0;

    case (state_q)
      IDLE: if (req_valid) begin
        addr_d  = req_addr;
        wdata_d = req_wdata;
        write_d = req_write;
        rdata_d = '0;
        cnt_d   = '0;
        state_d = REQ;
      end
      REQ: if (bgrant && sready) state_d = ADDR;
      ADDR: begin
        if (!bgrant) begin
          state_d = REQ;
          cnt_d   = '0;
        end else if (cnt_q == CW'(ADDR_WIDTH - 1)) begin
          cnt_d   = '0;
          state_d = write_q ? WDATA : RWAIT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      WDATA: begin
        if (!bgrant) begin
          state_d = REQ;
          cnt_d   = '0;
        end else if (cnt_q == CW'(DATA_WIDTH - 1)) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      // RWAIT takes bit 0 itself, so both states share the capture path; svalid beats msplit
      RWAIT, RDATA: begin
        if (svalid) begin
          rdata_d = rdata_q | (DATA_WIDTH'(sdata) << cnt_q);
          if (cnt_q == CW'(DATA_WIDTH - 1)) begin
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            cnt_d   = cnt_q + CW'(1);
            state_d = RDATA;
          end
        end else if (state_q == RWAIT && msplit) begin
          state_d = SPLIT;
        end
      end
      SPLIT:  if (!msplit) state_d = RESUME;
      RESUME: if (bgrant)  state_d = RWAIT;
      DONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase

`ifdef BUS_MASTER_PORT_TIMEOUT_EN
    to_d = to_q;
    if (state_q inside {RWAIT, RDATA, SPLIT}) begin
      if (svalid) begin
        to_d = '0;
      end else if (to_q == TW'(TIMEOUT_CYCLES - 1)) begin
        timeout = 1'b1;
        state_d = DONE;
        cnt_d   = '0;
      end else begin
        to_d = to_q + TW'(1);
      end
    end
    if (state_d != state_q) to_d = '0;
`endif

    // Outputs are registered from the next state so they change on the entering edge
    addr_sh     = addr_q >> cnt_d;
    wdata_sh    = wdata_q >> cnt_d;
    breq_d      = state_d inside {REQ, ADDR, WDATA, RWAIT, RDATA, RESUME};
    mvalid_d    = state_d inside {ADDR, WDATA};
    mdata_d     = (state_d == ADDR) ? addr_sh[0] : (state_d == WDATA) ? wdata_sh[0] : 1'b0;
    mmode_d     = (state_d inside {ADDR, WDATA, RWAIT, RDATA, SPLIT, RESUME}) ? write_q : 1'b0;
    rsp_valid_d = (state_d == DONE);
    rsp_err_d   = timeout;
    rsp_rdata_d = rsp_rdata_q;
    if (state_d == DONE && !write_q) rsp_rdata_d = timeout ? '0 : rdata_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      write_q     <= 1'b0;
      rdata_q     <= '0;
      breq_q      <= 1'b0;
      mvalid_q    <= 1'b0;
      mdata_q     <= 1'b0;
      mmode_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
`ifdef BUS_MASTER_PORT_TIMEOUT_EN
      to_q        <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      write_q     <= write_d;
      rdata_q     <= rdata_d;
      breq_q      <= breq_d;
      mvalid_q    <= mvalid_d;
      mdata_q     <= mdata_d;
      mmode_q     <= mmode_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
`ifdef BUS_MASTER_PORT_TIMEOUT_EN
      to_q        <= to_d;
`endif
    end
  end

  // A lost grant must silence the serial line in the cycle it is seen, not one edge later
  assign mvalid    = mvalid_q & bgrant;
  assign req_ready = (state_q == IDLE);
  assign breq      = breq_q;
  assign mdata     = mdata_q;
  assign mmode     = mmode_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_bus_master_port.sv
// Scoreboard bench for bus_master_port: serial bits and responses are queued at issue and checked on output.
module tb_bus_master_port;
  localparam int AW = 14;
  localparam int DW = 8;

  logic          clk, rst;
  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic          breq, bgrant, msplit, sready;
  logic          mvalid, mdata, mmode, svalid, sdata;

  bus_master_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .breq(breq), .bgrant(bgrant), .msplit(msplit), .sready(sready),
    .mvalid(mvalid), .mdata(mdata), .mmode(mmode),
    .svalid(svalid), .sdata(sdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int bits_seen = 0, rsp_seen = 0, rsp_cyc = 0;
  int bbase = 0, rbase = 0, acc_cyc = 0, n = 0;
  logic exp_mode = 1'b0;
  logic [DW-1:0] last_rd = '0;
  logic exp_bits[$];
  logic [DW:0] exp_rsp[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample at the falling edge against the scoreboard, return on the rising edge
  task automatic tick();
    logic       e;
    logic [DW:0] r;
    @(negedge clk);
    cyc++;
    if (mvalid) begin
      bits_seen++;
      if (exp_bits.size() == 0) chk("spurious_mvalid", mvalid, 0);
      else begin
        e = exp_bits.pop_front();
        chk("mdata", mdata, e);
        chk("mmode", mmode, exp_mode);
      end
    end
    if (rsp_valid) begin
      rsp_seen++;
      rsp_cyc = cyc;
      if (exp_rsp.size() == 0) chk("spurious_rsp_valid", rsp_valid, 0);
      else begin
        r = exp_rsp.pop_front();
        chk("rsp_rdata", rsp_rdata, r[DW-1:0]);
        chk("rsp_err", rsp_err, r[DW]);
      end
    end
    @(posedge clk);
  endtask

  task automatic issue(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [DW:0] er);
    #1;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    chk("req_ready_idle", req_ready, 1);
    for (int i = 0; i < AW; i++) exp_bits.push_back(a[i]);
    if (w) for (int i = 0; i < DW; i++) exp_bits.push_back(d[i]);
    exp_rsp.push_back(er);
    exp_mode = w;
    bbase = bits_seen;
    rbase = rsp_seen;
    tick();
    acc_cyc = cyc;
    #1 req_valid = 1'b0;
    chk("req_ready_busy", req_ready, 0);
  endtask

  task automatic wait_bits(input int cnt);
    int k = 0;
    while (bits_seen - bbase < cnt) begin
      if (k == 200) begin
        chk("wait_bits_timeout", bits_seen - bbase, cnt);
        return;
      end
      tick();
      k++;
    end
  endtask

  task automatic wait_rsp(output int k);
    k = 0;
    while (rsp_seen == rbase) begin
      if (k == 200) begin
        chk("wait_rsp_timeout", rsp_seen - rbase, 1);
        return;
      end
      tick();
      k++;
    end
  endtask

  task automatic slave_send(input logic [DW-1:0] v);
    for (int i = 0; i < DW; i++) begin
      #1 svalid = 1'b1; sdata = v[i];
      tick();
      if (i == 2 || i == 5) begin
        #1 svalid = 1'b0; sdata = 1'b0;
        tick();
      end
    end
    #1 svalid = 1'b0; sdata = 1'b0;
  endtask

  logic [AW-1:0] ga;

  initial begin
    rst = 1'b1; req_valid = 0; req_write = 0; req_addr = '0; req_wdata = '0;
    bgrant = 0; msplit = 0; sready = 0; svalid = 0; sdata = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_breq", breq, 0);      chk("rst_mvalid", mvalid, 0);
    chk("rst_mdata", mdata, 0);    chk("rst_mmode", mmode, 0);
    chk("rst_rsp_valid", rsp_valid, 0); chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_err", rsp_err, 0);     chk("rst_req_ready", req_ready, 1);
    rst = 1'b0; bgrant = 1'b1; sready = 1'b1;
    tick();

    // Write 0x1A5 / 0xC3 with continuous grant
    issue(1'b1, 14'h01A5, 8'hC3, {1'b0, last_rd});
    chk("wr_breq_after_accept", breq, 1);
    wait_rsp(n);
    chk("wr_latency", rsp_cyc - acc_cyc, 24);
    chk("wr_mvalid_cycles", bits_seen - bbase, 22);
    #1 chk("wr_breq_low_after", breq, 0);
    chk("wr_mmode_low_after", mmode, 0);
    chk("wr_bits_drained", exp_bits.size(), 0);

    // Read 0x0040, slave returns 0x5A with gaps after bits 2 and 5
    last_rd = 8'h5A;
    issue(1'b0, 14'h0040, 8'h00, {1'b0, last_rd});
    wait_bits(AW);
    #1 chk("rd_mvalid_off_rwait", mvalid, 0);
    chk("rd_breq_held_rwait", breq, 1);
    tick();
    slave_send(8'h5A);
    wait_rsp(n);
    repeat (3) tick();
    chk("rd_single_pulse", rsp_seen - rbase, 1);
    #1 chk("rd_rdata_held", rsp_rdata, 8'h5A);

    // Read with a 10-cycle split in RWAIT, then 0x81
    last_rd = 8'h81;
    issue(1'b0, 14'h2A7, 8'h00, {1'b0, last_rd});
    wait_bits(AW);
    #1 msplit = 1'b1; bgrant = 1'b0;
    tick();
    for (int i = 0; i < 9; i++) begin
      #1 chk("split_breq_low", breq, 0);
      tick();
    end
    #1 msplit = 1'b0;
    chk("split_breq_low_last", breq, 0);
    tick();
    #1 chk("resume_breq_high", breq, 1);
    tick();
    #1 chk("resume_wait_grant", breq, 1);
    bgrant = 1'b1;
    tick();
    slave_send(8'h81);
    wait_rsp(n);
    chk("split_no_addr_resend", bits_seen - bbase, AW);

    // Write with grant dropped while address bit 5 is on the line
    ga = 14'h2C3B;
    for (int i = 0; i < 5; i++) exp_bits.push_back(ga[i]);
    issue(1'b1, ga, 8'h96, {1'b0, last_rd});
    wait_bits(5);
    #1 bgrant = 1'b0;
    #1 chk("gl_mvalid_drop", mvalid, 0);
    chk("gl_breq_held", breq, 1);
    tick();
    #1 chk("gl_req_mvalid", mvalid, 0);
    tick();
    #1 bgrant = 1'b1;
    wait_rsp(n);
    chk("gl_bits_total", bits_seen - bbase, 5 + AW + DW);

    // Reset asserted while data bit 3 is on the line
    issue(1'b1, 14'h1234, 8'hA5, {1'b0, last_rd});
    wait_bits(AW + 3);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_breq", breq, 0);   chk("mid_rst_mvalid", mvalid, 0);
    chk("mid_rst_mdata", mdata, 0); chk("mid_rst_mmode", mmode, 0);
    chk("mid_rst_rsp_valid", rsp_valid, 0); chk("mid_rst_rsp_rdata", rsp_rdata, 0);
    chk("mid_rst_rsp_err", rsp_err, 0);
    exp_bits.delete();
    exp_rsp.delete();
    last_rd = '0;
    rbase = rsp_seen;
    tick(); tick();
    #1 rst = 1'b0;
    tick();
    #1 chk("post_rst_req_ready", req_ready, 1);
    chk("post_rst_breq", breq, 0);
    repeat (30) tick();
    chk("post_rst_no_rsp", rsp_seen - rbase, 0);

`ifdef BUS_MASTER_PORT_TIMEOUT_EN
    // Read with no slave response: timeout after 16 RWAIT cycles
    issue(1'b0, 14'h03FF, 8'h00, {1'b1, 8'h00});
    wait_bits(AW);
    wait_rsp(n);
    chk("to_latency", n, 17);
    #1 chk("to_breq_low", breq, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
